// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the BCD converter family: FSM states, BCD constants, digit sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Number of internal BCD digits needed to hold any width-bit magnitude
    // without loss: each group of ~3.32 bits needs one decimal digit, so
    // ceil(width/3) always suffices. Never fewer than the presented digits.
    function automatic int int_digits(input int width, input int digits);
        int need;
        need = (width + 2) / 3;
        return (digits > need) ? digits : need;
    endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
// Latency: combinational.
// Backpressure: none.
// Ports: digit - current BCD digit; fixed - corrected digit.
module bin2bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock), optional signed input.
// Latency: start accepted at edge 0 -> o_DV pulse after edge INPUT_WIDTH+1; one result per INPUT_WIDTH+2 cycles.
// Backpressure: o_Ready high only in IDLE; i_Start while busy is dropped, not queued.
// Ports: i_Clock/i_Reset_n clock and async active-low reset; i_Start/i_Binary request and operand;
//        o_Ready idle flag; o_BCD/o_Sign/o_Overflow result (held until next o_DV); o_DV result strobe.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int INPUT_WIDTH    = 8,
    parameter int DECIMAL_DIGITS = 3,
    parameter int SIGNED         = 0
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Start,
    input  logic [INPUT_WIDTH-1:0]        i_Binary,
    output logic                          o_Ready,
    output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
    output logic                          o_Sign,
    output logic                          o_Overflow,
    output logic                          o_DV
);

    localparam int INT_DIGITS = int_digits(INPUT_WIDTH, DECIMAL_DIGITS);
    localparam int BCD_W      = INT_DIGITS * 4;
    localparam int SCR_W      = BCD_W + INPUT_WIDTH;
    localparam int CNT_W      = $clog2(INPUT_WIDTH + 1);

    localparam logic [INPUT_WIDTH-1:0] ONE_W   = INPUT_WIDTH'(1);
    localparam logic [CNT_W-1:0]       ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       STEPS_C = CNT_W'(INPUT_WIDTH);

    state_t               state, state_nxt;
    logic [SCR_W-1:0]     scratch, scratch_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 sign_q, sign_nxt;

    logic [BCD_W-1:0]     corrected;
    logic [SCR_W-1:0]     pre_shift;
    logic                 neg;
    logic [INPUT_WIDTH-1:0] mag;
    logic                 ovf_c;
    logic                 bcd_zero;

    // Scratch layout: {digit INT_DIGITS-1 .. digit 0, binary shift bits}.
    // Every digit is corrected in parallel, then the whole word shifts left.
    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
        bin2bcd_add3 u_add3 (
            .digit (scratch[INPUT_WIDTH + 4*g +: 4]),
            .fixed (corrected[4*g +: 4])
        );
    end

    assign pre_shift = {corrected, scratch[INPUT_WIDTH-1:0]};

    // Two's-complement negate in INPUT_WIDTH bits maps -2^(W-1) onto the
    // unsigned value 2^(W-1), which still fits, so the most negative input
    // converts exactly.
    assign neg = (SIGNED != 0) && i_Binary[INPUT_WIDTH-1];
    assign mag = neg ? (~i_Binary + ONE_W) : i_Binary;

    // Any non-zero digit beyond the presented ones means the value cannot be shown.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = DECIMAL_DIGITS; i < INT_DIGITS; i++) begin
            if (scratch[INPUT_WIDTH + 4*i +: 4] != 4'd0) begin
                ovf_c = 1'b1;
            end
        end
    end

    // After the last shift the scratch BCD field holds the full magnitude.
    assign bcd_zero = (scratch[SCR_W-1:INPUT_WIDTH] == '0);

    assign o_Ready = (state == ST_IDLE);

    always_comb begin
        state_nxt   = state;
        scratch_nxt = scratch;
        count_nxt   = count;
        sign_nxt    = sign_q;
        case (state)
            ST_IDLE: begin
                if (i_Start) begin
                    scratch_nxt = {{BCD_W{1'b0}}, mag};
                    sign_nxt    = neg;
                    count_nxt   = STEPS_C;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_nxt = pre_shift << 1;
                count_nxt   = count - ONE_C;
                if (count == ONE_C) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= ST_IDLE;
            scratch <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            scratch <= scratch_nxt;
            count   <= count_nxt;
            sign_q  <= sign_nxt;
        end
    end

    // Result registers only load while leaving DONE, so they hold steady
    // between strobes.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_BCD      <= '0;
            o_Sign     <= 1'b0;
            o_Overflow <= 1'b0;
            o_DV       <= 1'b0;
        end else begin
            o_DV <= (state == ST_DONE);
            if (state == ST_DONE) begin
                o_Overflow <= ovf_c;
                o_BCD      <= ovf_c ? {DECIMAL_DIGITS{BCD_NINE}}
                                    : scratch[INPUT_WIDTH +: DECIMAL_DIGITS*4];
                o_Sign     <= sign_q && !bcd_zero;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    // Instance configurations: index -> (width, digits, signed)
    localparam int PW [5] = '{6, 8, 8, 10, 10};
    localparam int PD [5] = '{2, 2, 3, 4, 4};
    localparam int PS [5] = '{0, 0, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  start;
    logic [5:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [9:0]  b3;
    logic [9:0]  b4;

    logic [4:0]  rdy_a, dv_a, sign_a, ovf_a;
    logic [7:0]  bcd0, bcd1;
    logic [11:0] bcd2;
    logic [15:0] bcd3, bcd4;
    logic [15:0] bcd_a [5];

    int n_vec = 0;
    int n_err = 0;
    int dv_cnt [5] = '{0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    bin2bcd_seq #(.INPUT_WIDTH(6), .DECIMAL_DIGITS(2), .SIGNED(0)) u0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start[0]), .i_Binary(b0),
        .o_Ready(rdy_a[0]), .o_BCD(bcd0), .o_Sign(sign_a[0]), .o_Overflow(ovf_a[0]), .o_DV(dv_a[0]));
    bin2bcd_seq #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(2), .SIGNED(0)) u1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start[1]), .i_Binary(b1),
        .o_Ready(rdy_a[1]), .o_BCD(bcd1), .o_Sign(sign_a[1]), .o_Overflow(ovf_a[1]), .o_DV(dv_a[1]));
    bin2bcd_seq #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(1)) u2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start[2]), .i_Binary(b2),
        .o_Ready(rdy_a[2]), .o_BCD(bcd2), .o_Sign(sign_a[2]), .o_Overflow(ovf_a[2]), .o_DV(dv_a[2]));
    bin2bcd_seq #(.INPUT_WIDTH(10), .DECIMAL_DIGITS(4), .SIGNED(0)) u3 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start[3]), .i_Binary(b3),
        .o_Ready(rdy_a[3]), .o_BCD(bcd3), .o_Sign(sign_a[3]), .o_Overflow(ovf_a[3]), .o_DV(dv_a[3]));
    bin2bcd_seq #(.INPUT_WIDTH(10), .DECIMAL_DIGITS(4), .SIGNED(1)) u4 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start[4]), .i_Binary(b4),
        .o_Ready(rdy_a[4]), .o_BCD(bcd4), .o_Sign(sign_a[4]), .o_Overflow(ovf_a[4]), .o_DV(dv_a[4]));

    assign bcd_a[0] = {8'h00, bcd0};
    assign bcd_a[1] = {8'h00, bcd1};
    assign bcd_a[2] = {4'h0, bcd2};
    assign bcd_a[3] = bcd3;
    assign bcd_a[4] = bcd4;

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (dv_a[k]) dv_cnt[k]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on the integer value.
    function automatic void model(input int k, input int val,
                                  output logic [15:0] bcd, output logic sgn, output logic ov);
        int  w, d, mag, lim, tmp;
        logic neg;
        w   = PW[k];
        d   = PD[k];
        mag = val;
        neg = 1'b0;
        if (PS[k] != 0 && val >= (1 << (w - 1))) begin
            neg = 1'b1;
            mag = (1 << w) - val;
        end
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        lim = lim - 1;
        ov  = (mag > lim);
        sgn = neg && (mag != 0);
        bcd = '0;
        tmp = mag;
        for (int i = 0; i < d; i++) begin
            bcd[4*i +: 4] = ov ? 4'd9 : 4'(tmp % 10);
            tmp = tmp / 10;
        end
    endfunction

    task automatic set_bin(input int k, input int v);
        case (k)
            0: b0 = 6'(v);
            1: b1 = 8'(v);
            2: b2 = 8'(v);
            3: b3 = 10'(v);
            default: b4 = 10'(v);
        endcase
    endtask

    task automatic convert(input int k, input int val);
        logic [15:0] eb;
        logic        es, eo;
        int          lat;
        model(k, val, eb, es, eo);
        @(negedge clk);
        set_bin(k, val);
        start[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[k] = 1'b0;
        check($sformatf("k%0d v%0d ready_busy", k, val), {31'b0, rdy_a[k]}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!dv_a[k] && lat < 40);
        check($sformatf("k%0d v%0d latency", k, val), lat, PW[k] + 1);
        check($sformatf("k%0d v%0d bcd", k, val), {16'b0, bcd_a[k]}, {16'b0, eb});
        check($sformatf("k%0d v%0d sign", k, val), {31'b0, sign_a[k]}, {31'b0, es});
        check($sformatf("k%0d v%0d ovf", k, val), {31'b0, ovf_a[k]}, {31'b0, eo});
    endtask

    initial begin
        int          d_before;
        int          t;
        int          n_seen;
        int          cyc;
        int          cyc_seen [2];
        logic [15:0] bcd_seen [2];
        logic [15:0] held;

        rst_n = 1'b0;
        start = '0;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst k%0d ready", k), {31'b0, rdy_a[k]}, 32'd1);
            check($sformatf("rst k%0d dv", k), {31'b0, dv_a[k]}, 32'd0);
            check($sformatf("rst k%0d bcd", k), {16'b0, bcd_a[k]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        convert(0, 31);
        convert(0, 63);
        convert(1, 255);
        convert(1, 99);
        convert(1, 0);
        convert(2, 128);
        convert(2, 127);
        convert(2, 255);
        convert(2, 0);

        // Result held after the strobe
        held = bcd_a[2];
        repeat (3) @(negedge clk);
        check("hold bcd", {16'b0, bcd_a[2]}, {16'b0, held});
        check("hold dv", {31'b0, dv_a[2]}, 32'd0);

        // Start while busy is ignored
        d_before = dv_cnt[0];
        @(negedge clk);
        b0 = 6'd31;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        b0 = 6'd50;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        b0 = 6'd9;
        t = 0;
        while (!dv_a[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy first result", {16'b0, bcd_a[0]}, 32'h31);
        repeat (12) @(negedge clk);
        check("busy single dv", dv_cnt[0] - d_before, 1);

        // Reset in the middle of a conversion
        d_before = dv_cnt[3];
        @(negedge clk);
        b3 = 10'd700;
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ready", {31'b0, rdy_a[3]}, 32'd1);
        check("midrst bcd", {16'b0, bcd_a[3]}, 32'd0);
        check("midrst ovf", {31'b0, ovf_a[3]}, 32'd0);
        check("midrst other bcd", {16'b0, bcd_a[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst no dv", dv_cnt[3] - d_before, 0);
        convert(3, 700);

        // Back-to-back with start held high
        n_seen = 0;
        cyc = 0;
        @(negedge clk);
        b0 = 6'd12;
        start[0] = 1'b1;
        @(negedge clk);
        b0 = 6'd34;
        while (n_seen < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dv_a[0]) begin
                cyc_seen[n_seen] = cyc;
                bcd_seen[n_seen] = bcd_a[0];
                n_seen++;
                if (n_seen == 2) start[0] = 1'b0;
            end
        end
        start[0] = 1'b0;
        check("b2b count", n_seen, 2);
        if (n_seen == 2) begin
            check("b2b spacing", cyc_seen[1] - cyc_seen[0], 8);
            check("b2b first", {16'b0, bcd_seen[0]}, 32'h12);
            check("b2b second", {16'b0, bcd_seen[1]}, 32'h34);
        end
        repeat (12) @(negedge clk);

        // Randomized values on the small configurations
        for (int i = 0; i < 30; i++) begin
            convert(0, $urandom_range(0, 63));
            convert(1, $urandom_range(0, 255));
            convert(2, $urandom_range(0, 255));
        end

        // Exhaustive sweep of both 10-bit configurations in parallel
        fork
            begin
                for (int v = 0; v < 1024; v++) convert(3, v);
            end
            begin
                for (int v = 0; v < 1024; v++) convert(4, v);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
